// File: rtl/mem_stage_if.sv
// EX/MEM-to-MEM bus: address, store data and strobes in,
// load data and write-back value out.
interface mem_stage_if;
    logic [31:0] Mem_in;
    logic [31:0] Mem_BusB;
    logic        Mem_MemWr;
    logic        Mem_MemRd;
    logic [1:0]  Mem_MemtoReg;
    logic [31:0] Mem_PC;
    logic [31:0] Mem_RdData;
    logic [31:0] Mem_WrData;

    modport master (
        output Mem_in, Mem_BusB, Mem_MemWr,
        output Mem_MemRd, Mem_MemtoReg, Mem_PC,
        input  Mem_RdData, Mem_WrData
    );

    modport slave (
        input  Mem_in, Mem_BusB, Mem_MemWr,
        input  Mem_MemRd, Mem_MemtoReg, Mem_PC,
        output Mem_RdData, Mem_WrData
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: data RAM, memory-mapped timer/LED/switch/
// 7-segment/systick block and write-back select.
module mem_stage #(
    parameter int RAM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  bus,
    input  logic [7:0]  switch,
    output logic [7:0]  led,
    output logic [11:0] digi,
    output logic        irq
);
    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0] ram [RAM_WORDS];
    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic [31:0] systick;
    logic [31:0] rd_data;
    logic [31:0] pc_plus4;

    logic [AW-1:0] word;
    logic [29:0]   wa;
    logic sel_ram, sel_th, sel_tl, sel_tcon;
    logic sel_led, sel_sw, sel_digi, sel_tick;
    logic wr;
    logic unused;

    assign word = bus.Mem_in[AW+1:2];
    assign wa   = bus.Mem_in[31:2];
    assign wr   = bus.Mem_MemWr;
    assign unused = ^bus.Mem_in[1:0];

    assign sel_ram  = (bus.Mem_in[31:AW+2] == '0);
    assign sel_th   = (wa == 30'h1000_0000);
    assign sel_tl   = (wa == 30'h1000_0001);
    assign sel_tcon = (wa == 30'h1000_0002);
    assign sel_led  = (wa == 30'h1000_0003);
    assign sel_sw   = (wa == 30'h1000_0004);
    assign sel_digi = (wa == 30'h1000_0005);
    assign sel_tick = (wa == 30'h1000_0006);

    always_comb begin
        rd_data = '0;
        if (bus.Mem_MemRd) begin
            unique case (1'b1)
                sel_ram:  rd_data = ram[word];
                sel_th:   rd_data = th;
                sel_tl:   rd_data = tl;
                sel_tcon: rd_data = {29'd0, tcon};
                sel_led:  rd_data = {24'd0, led};
                sel_sw:   rd_data = {24'd0, switch};
                sel_digi: rd_data = {20'd0, digi};
                sel_tick: rd_data = systick;
                default:  rd_data = '0;
            endcase
        end
    end

    assign bus.Mem_RdData = rd_data;
    assign pc_plus4 = bus.Mem_PC + 32'd4;

    always_comb begin
        unique case (bus.Mem_MemtoReg)
            2'd1:    bus.Mem_WrData = rd_data;
            2'd2:    bus.Mem_WrData = pc_plus4;
            default: bus.Mem_WrData = bus.Mem_in;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr && sel_ram)
            ram[word] <= bus.Mem_BusB;
    end

    // CPU writes come after the timer update so they take priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th      <= '0;
            tl      <= '0;
            tcon    <= '0;
            led     <= '0;
            digi    <= '0;
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
            if (tcon[0]) begin
                if (&tl) begin
                    tl <= th;
                    if (tcon[1])
                        tcon[2] <= 1'b1;
                end else begin
                    tl <= tl + 32'd1;
                end
            end
            if (wr && sel_th)   th   <= bus.Mem_BusB;
            if (wr && sel_tl)   tl   <= bus.Mem_BusB;
            if (wr && sel_tcon) tcon <= bus.Mem_BusB[2:0];
            if (wr && sel_led)  led  <= bus.Mem_BusB[7:0];
            if (wr && sel_digi) digi <= bus.Mem_BusB[11:0];
        end
    end

    assign irq = tcon[1] & tcon[2];
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed table, timer/reset sequences and
// a randomized run against a behavioural model.
module tb_mem_stage;
    localparam int RAM_WORDS = 256;
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);
    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_DIGI = 32'h4000_0014;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  switch = 8'h3C;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        irq;
    int checks = 0;
    int errors = 0;

    mem_stage_if bus ();

    mem_stage #(.RAM_WORDS(RAM_WORDS)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .switch(switch), .led(led), .digi(digi), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        rd;
        logic [1:0]  mtr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
        logic [31:0] exp_rd;
        logic [31:0] exp_wr;
    } vec_t;

    vec_t tbl [$];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic set_bus(input logic we, input logic rd,
                           input logic [31:0] addr,
                           input logic [31:0] data);
        bus.Mem_MemWr = we;
        bus.Mem_MemRd = rd;
        bus.Mem_in = addr;
        bus.Mem_BusB = data;
    endtask

    task automatic rd_chk(input string name,
                          input logic [31:0] addr,
                          input logic [31:0] exp);
        set_bus(1'b0, 1'b1, addr, 32'h0);
        #1;
        check(name, bus.Mem_RdData, exp);
    endtask

    task automatic wr_cyc(input logic [31:0] addr,
                          input logic [31:0] data);
        @(negedge clk);
        set_bus(1'b1, 1'b0, addr, data);
        @(posedge clk);
        #1;
    endtask

    // Behavioural model
    logic [31:0] m_ram [int unsigned];
    logic [31:0] m_th, m_tl, m_tick;
    logic [2:0]  m_tcon;
    logic [7:0]  m_led;
    logic [11:0] m_digi;

    task automatic model_reset();
        m_th = 0; m_tl = 0; m_tick = 0;
        m_tcon = 0; m_led = 0; m_digi = 0;
    endtask

    function automatic bit model_read(input logic [31:0] a,
                                      output logic [31:0] v);
        v = 0;
        if (a < RAM_BYTES) begin
            if (!m_ram.exists(a >> 2)) return 0;
            v = m_ram[a >> 2];
            return 1;
        end
        case (a & ~32'h3)
            A_TH:          v = m_th;
            A_TL:          v = m_tl;
            A_TCON:        v = {29'd0, m_tcon};
            A_LED:         v = {24'd0, m_led};
            32'h4000_0010: v = {24'd0, switch};
            A_DIGI:        v = {20'd0, m_digi};
            32'h4000_0018: v = m_tick;
            default:       v = 0;
        endcase
        return 1;
    endfunction

    task automatic model_edge(input logic we,
                              input logic [31:0] a,
                              input logic [31:0] d);
        if (m_tcon[0]) begin
            if (m_tl == 32'hFFFF_FFFF) begin
                m_tl = m_th;
                if (m_tcon[1]) m_tcon[2] = 1'b1;
            end else begin
                m_tl = m_tl + 1;
            end
        end
        m_tick = m_tick + 1;
        if (we) begin
            if (a < RAM_BYTES) m_ram[a >> 2] = d;
            else case (a & ~32'h3)
                A_TH:    m_th = d;
                A_TL:    m_tl = d;
                A_TCON:  m_tcon = d[2:0];
                A_LED:   m_led = d[7:0];
                A_DIGI:  m_digi = d[11:0];
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int k = int'($urandom_range(0, 9));
        logic [31:0] lo = 32'($urandom_range(0, 3));
        if (k < 4) return 32'($urandom_range(0, 15)) * 4 + lo;
        if (k < 9) return A_TH + 32'($urandom_range(0, 6)) * 4 + lo;
        case ($urandom_range(0, 2))
            0: return 32'h4000_0020 + 32'($urandom_range(0, 7)) * 4;
            1: return RAM_BYTES + 32'($urandom_range(0, 255));
            default: return 32'h8000_0000 | 32'($urandom);
        endcase
    endfunction

    logic [31:0] v, a, d, exp_wr;
    logic        we, known;

    initial begin
        set_bus(1'b0, 1'b0, 32'h0, 32'h0);
        bus.Mem_MemtoReg = 2'd0;
        bus.Mem_PC = 32'h0;
        #12;
        #1;
        check("reset_led", {24'd0, led}, 32'h0);
        check("reset_digi", {20'd0, digi}, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);
        rd_chk("reset_tl", A_TL, 32'h0);
        rd_chk("reset_tcon", A_TCON, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        tbl.push_back('{1, 0, 0, 32'h10, 32'hDEADBEEF, 0, 0, 32'h10});
        tbl.push_back('{0, 1, 1, 32'h10, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF});
        tbl.push_back('{0, 1, 1, 32'h13, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF});
        tbl.push_back('{0, 1, 1, 32'h2000_0000, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 32'h4000_0010, 32'hFF, 0, 0, 32'h4000_0010});
        tbl.push_back('{0, 1, 1, 32'h4000_0010, 0, 0, 32'h3C, 32'h3C});
        tbl.push_back('{1, 0, 3, A_LED, 32'h1A5, 0, 0, A_LED});
        tbl.push_back('{0, 1, 1, A_LED, 0, 0, 32'hA5, 32'hA5});
        tbl.push_back('{1, 0, 2, A_DIGI, 32'hFABC, 32'h0040_0010, 0, 32'h0040_0014});
        tbl.push_back('{0, 1, 1, A_DIGI, 0, 0, 32'hABC, 32'hABC});
        tbl.push_back('{1, 1, 1, 32'h10, 32'h1111_1111, 0, 32'hDEADBEEF, 32'hDEADBEEF});
        tbl.push_back('{0, 1, 1, 32'h10, 0, 0, 32'h1111_1111, 32'h1111_1111});
        tbl.push_back('{0, 0, 0, 32'h1234, 0, 0, 0, 32'h1234});
        tbl.push_back('{1, 0, 0, 32'h0, 32'hCAFE_0000, 0, 0, 32'h0});
        tbl.push_back('{1, 0, 0, 32'h2000_0000, 32'h55, 0, 0, 32'h2000_0000});
        tbl.push_back('{0, 1, 1, 32'h0, 0, 0, 32'hCAFE_0000, 32'hCAFE_0000});
        tbl.push_back('{0, 1, 0, 32'h4000_0008, 0, 0, 0, 32'h4000_0008});

        foreach (tbl[i]) begin
            set_bus(tbl[i].we, tbl[i].rd, tbl[i].addr, tbl[i].data);
            bus.Mem_MemtoReg = tbl[i].mtr;
            bus.Mem_PC = tbl[i].pc;
            #1;
            check($sformatf("vec%0d_rd", i), bus.Mem_RdData, tbl[i].exp_rd);
            check($sformatf("vec%0d_wr", i), bus.Mem_WrData, tbl[i].exp_wr);
            @(negedge clk);
        end
        check("led_a5", {24'd0, led}, 32'hA5);
        check("digi_abc", {20'd0, digi}, 32'hABC);
        bus.Mem_MemtoReg = 2'd1;

        // Timer overflow, irq clear, TL write during overflow
        wr_cyc(A_TH, 32'hFFFF_FFFD);
        wr_cyc(A_TL, 32'hFFFF_FFFE);
        wr_cyc(A_TCON, 32'h3);
        @(negedge clk);
        rd_chk("tl_start", A_TL, 32'hFFFF_FFFE);
        @(posedge clk);
        @(negedge clk);
        rd_chk("tl_ff", A_TL, 32'hFFFF_FFFF);
        check("irq_pre", {31'd0, irq}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rd_chk("tl_reload", A_TL, 32'hFFFF_FFFD);
        rd_chk("tcon_7", A_TCON, 32'h7);
        check("irq_set", {31'd0, irq}, 32'h1);
        set_bus(1'b1, 1'b0, A_TCON, 32'h3);
        @(posedge clk);
        #1;
        check("irq_clr", {31'd0, irq}, 32'h0);
        @(negedge clk);
        set_bus(1'b0, 1'b1, A_TL, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rd_chk("tl_ff2", A_TL, 32'hFFFF_FFFF);
        set_bus(1'b1, 1'b0, A_TL, 32'h5);
        @(posedge clk);
        #1;
        check("irq_tlwr", {31'd0, irq}, 32'h1);
        @(negedge clk);
        rd_chk("tl_cpu_wins", A_TL, 32'h5);
        rd_chk("tcon_tlwr", A_TCON, 32'h7);

        // Asynchronous reset mid-count
        wr_cyc(A_LED, 32'h5A);
        wr_cyc(A_DIGI, 32'h123);
        @(negedge clk);
        set_bus(1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        check("irq_before_rst", {31'd0, irq}, 32'h1);
        reset = 1'b1;
        #1;
        check("rst_led", {24'd0, led}, 32'h0);
        check("rst_digi", {20'd0, digi}, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        rd_chk("rst_tl", A_TL, 32'h0);
        rd_chk("rst_tcon", A_TCON, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rd_chk("tl_stays0", A_TL, 32'h0);

        // Randomized run against the model
        #1;
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        set_bus(1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            a = rand_addr();
            d = $urandom;
            if ((a & ~32'h3) == A_TH || (a & ~32'h3) == A_TL)
                if ($urandom_range(0, 3) != 0)
                    d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            we = ($urandom_range(0, 2) == 0);
            set_bus(we, 1'($urandom_range(0, 1)), a, d);
            bus.Mem_MemtoReg = 2'($urandom_range(0, 3));
            bus.Mem_PC = $urandom;
            #1;
            known = model_read(a, v);
            if (!bus.Mem_MemRd) begin
                v = 0;
                known = 1;
            end
            if (known) check("rnd_rd", bus.Mem_RdData, v);
            case (bus.Mem_MemtoReg)
                2'd1: exp_wr = v;
                2'd2: exp_wr = bus.Mem_PC + 32'd4;
                default: exp_wr = a;
            endcase
            if (known || bus.Mem_MemtoReg != 2'd1)
                check("rnd_wr", bus.Mem_WrData, exp_wr);
            @(posedge clk);
            model_edge(we, a, d);
            #1;
            check("rnd_led", {24'd0, led}, {24'd0, m_led});
            check("rnd_digi", {20'd0, digi}, {20'd0, m_digi});
            check("rnd_irq", {31'd0, irq},
                  {31'd0, m_tcon[1] & m_tcon[2]});
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage MIPS pipeline, directly downstream of the EX/MEM pipeline register. Decodes the ALU result as a byte address into a word-addressed data RAM or a memory-mapped peripheral block (timer, LEDs, switches, 7-segment digits, systick). It also selects the write-back value passed on to the MEM/WB register. Owns the only timer-interrupt source in the design.

## Interface
- RAM_WORDS, 256, data RAM depth in 32-bit words; power of two; indexed by Mem_in[log2(RAM_WORDS)+1:2]
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- Mem_in  in  32  ALU result; byte address for loads/stores
- Mem_BusB  in  32  store data
- Mem_MemWr  in  1  store strobe
- Mem_MemRd  in  1  load strobe
- Mem_MemtoReg  in  2  write-back select: 0 ALU result, 1 load data, 2 PC+4, 3 ALU result
- Mem_PC  in  32  PC of the instruction in this stage
- switch  in  8  board switches
- Mem_RdData  out  32  load data (combinational)
- Mem_WrData  out  32  write-back value to MEM/WB (combinational)
- led  out  8  LED register
- digi  out  12  7-segment register
- irq  out  1  timer interrupt request

## Operation
- Address map (Mem_in[1:0] ignored, no alignment trap):
  - 0x00000000–(4·RAM_WORDS−1): data RAM
  - 0x40000000 TH (reload), 0x40000004 TL (count), 0x40000008 TCON[2:0] = {status, irq_en, enable}
  - 0x4000000C led[7:0], 0x40000010 switch (read-only), 0x40000014 digi[11:0], 0x40000018 systick (read-only)
- Unmapped addresses: reads return 0; writes ignored.
- Writes to read-only registers are ignored. Narrow registers read back zero-extended and take the low bits of Mem_BusB on write.
- Reads: Mem_RdData valid whenever Mem_MemRd=1; it is 0 when Mem_MemRd=0.
- Writes: only when Mem_MemWr=1, committed at the rising edge.
- Timer, on each clk with TCON[0]=1:
  - If TL==0xFFFFFFFF: TL←TH, and if TCON[1] then TCON[2]←1.
  - Otherwise TL←TL+1. Arithmetic is mod 2^32.
- irq = TCON[1] & TCON[2], registered-state derived; no combinational path from inputs.
- Systick increments every cycle, wraps at 2^32.
- Mem_WrData = mux(Mem_MemtoReg) of Mem_in, Mem_RdData, Mem_PC+4, Mem_in.

## Timing
- Reset:
  - TH, TL, TCON, led, digi and systick clear to 0 immediately; irq=0.
  - RAM contents are not cleared.
  - Reset asserted mid-count aborts the count; counting does not resume until TCON is rewritten.
- Load latency 0 cycles: data is combinational from the current address.
- A store is visible to a load at the same address one cycle later.
- MemRd and MemWr both set at the same address: Mem_RdData returns the pre-edge value.
- Overflow at edge k: TL=TH and irq=1 after edge k.
- CPU write to TL in the same cycle as a timer update: the CPU write wins.
- CPU write to TCON in the same cycle as an overflow: the CPU value wins for TCON; TL still reloads from TH.
- Writing TCON[2]=0 clears irq after that edge. Software writing TCON[2]=1 forces irq if TCON[1]=1.
- TCON[0]=0 freezes TL and status; systick is unaffected.

## Test plan
- Store 0xDEADBEEF to address 0x10, then load 0x10 and 0x13 the next cycle -> Mem_RdData=0xDEADBEEF for both. With MemtoReg=1 -> Mem_WrData=0xDEADBEEF.
- Load 0x20000000 -> 0. Store to 0x40000010 and 0x40000018 -> registers unchanged. Store 0x1A5 to 0x4000000C -> led=0xA5.
- TH=0xFFFFFFFD, TL=0xFFFFFFFE, TCON=3:
  - 1 clk -> TL=0xFFFFFFFF, irq=0
  - next clk -> TL=0xFFFFFFFD, TCON=7, irq=1
  - write TCON=3 -> irq=0 after the edge
- Write TL=0x5 in the overflow cycle -> TL=0x5. TCON[2] still sets; irq=1.
- Counting with TCON=3, assert reset asynchronously between edges -> TL, TCON, led, digi, irq=0 immediately; TL stays 0 after reset release.
- Mem_PC=0x00400010, MemtoReg=2 -> Mem_WrData=0x00400014. MemtoReg=0, Mem_in=0x1234 -> 0x1234.
